// File: rtl/product_accumulator_if.sv
// Handshake/data bundle between the product accumulator and its neighbours:
// product input side, batch control, and the accumulated result.
interface product_accumulator_if #(
    parameter int N     = 8,
    parameter int ACC_W = 9
);
    localparam int CNT_W = $clog2(N + 1);

    logic             start;
    logic             p_valid;
    logic [5:0]       p_in;
    logic             ack;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, p_valid, p_in, ack,
        input  acc, count, busy, done, overflow
    );

    modport slave (
        input  start, p_valid, p_in, ack,
        output acc, count, busy, done, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a batch of N unsigned 6-bit multiplier products into an ACC_W-bit
// accumulator, reporting the result with a done/ack handshake and a sticky overflow.
module product_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    product_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [ACC_W-1:0] acc_r, acc_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             overflow_r, overflow_s;
    logic             busy_r, done_r;
    logic [ACC_W:0]   sum_s;

    // One extra bit on the add exposes the carry out of the accumulator
    function automatic logic [ACC_W:0] add_product(input logic [ACC_W-1:0] a,
                                                   input logic [5:0]       p);
        return {1'b0, a} + {{(ACC_W - 5){1'b0}}, p};
    endfunction

    // Widened sum of the current accumulator and the incoming product
    always_comb begin
        sum_s = add_product(acc_r, bus.p_in);
    end

    // Next-state and next-datapath values
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s    = ACCUM;
                    acc_s      = ACC_W'(0);
                    count_s    = CNT_W'(0);
                    overflow_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (bus.p_valid) begin
                    acc_s   = sum_s[ACC_W-1:0];
                    count_s = count_r + CNT_W'(1);
                    if (sum_s[ACC_W]) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                    if (count_r == LAST_CNT) begin
                        state_s = DONE;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            DONE: begin
                // start only counts when paired with ack, giving back-to-back batches
                if (bus.ack && bus.start) begin
                    state_s    = ACCUM;
                    acc_s      = ACC_W'(0);
                    count_s    = CNT_W'(0);
                    overflow_s = 1'b0;
                end else if (bus.ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            acc_r      <= ACC_W'(0);
            count_r    <= CNT_W'(0);
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            acc_r      <= acc_s;
            count_r    <= count_s;
            overflow_r <= overflow_s;
            busy_r     <= (state_s == ACCUM);
            done_r     <= (state_s == DONE);
        end
    end

    assign bus.acc      = acc_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a batch-level reference model feeds a scoreboard
// that a separate monitor drains whenever the DUT raises done.
module tb_product_accumulator;
    localparam int N      = 8;
    localparam int ACC_W  = 8;
    localparam int NB     = 1;
    localparam int ACC_WB = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       p_valid;
    logic [5:0] p_in;
    logic       ack;

    always #5 clk = ~clk;

    product_accumulator_if #(.N(N),  .ACC_W(ACC_W))  bus_a ();
    product_accumulator_if #(.N(NB), .ACC_W(ACC_WB)) bus_b ();

    assign bus_a.start   = start;
    assign bus_a.p_valid = p_valid;
    assign bus_a.p_in    = p_in;
    assign bus_a.ack     = ack;
    assign bus_b.start   = start;
    assign bus_b.p_valid = p_valid;
    assign bus_b.p_in    = p_in;
    assign bus_b.ack     = ack;

    product_accumulator #(.N(N), .ACC_W(ACC_W)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    product_accumulator #(.N(NB), .ACC_W(ACC_WB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int acc;
        int cnt;
        int ovf;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   batch[$];
    exp_t sb[$];
    bit   prev_done = 1'b0;

    function automatic int batch_sum();
        int s = 0;
        foreach (batch[i]) s += batch[i];
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a batch is just the list of accepted products since start
    task automatic model_step(input bit rs, input bit st, input bit pv,
                              input bit [5:0] pi, input bit ak);
        exp_t e;
        if (rs) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            batch.delete();
            sb.delete();
        end else if (m_busy) begin
            if (pv) begin
                batch.push_back(int'(pi));
                if (batch.size() == N) begin
                    e.acc = batch_sum() % (1 << ACC_W);
                    e.cnt = N;
                    e.ovf = (batch_sum() >= (1 << ACC_W)) ? 1 : 0;
                    sb.push_back(e);
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            if (ak) begin
                m_done = 1'b0;
                if (st) begin
                    m_busy = 1'b1;
                    batch.delete();
                end
            end
        end else if (st) begin
            m_busy = 1'b1;
            batch.delete();
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input bit pv,
                         input bit [5:0] pi, input bit ak);
        reset   = rs;
        start   = st;
        p_valid = pv;
        p_in    = pi;
        ack     = ak;
        model_step(rs, st, pv, pi, ak);
        @(posedge clk);
        #1;
        check("acc",      int'(bus_a.acc),      batch_sum() % (1 << ACC_W));
        check("count",    int'(bus_a.count),    batch.size());
        check("busy",     int'(bus_a.busy),     int'(m_busy));
        check("done",     int'(bus_a.done),     int'(m_done));
        check("overflow", int'(bus_a.overflow), (batch_sum() >= (1 << ACC_W)) ? 1 : 0);
    endtask

    // Monitor: each rising done presents one batch result to the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: done rose with no expected result, acc=%0d", bus_a.acc);
            end else begin
                e = sb.pop_front();
                check("sb_acc",      int'(bus_a.acc),      e.acc);
                check("sb_count",    int'(bus_a.count),    e.cnt);
                check("sb_overflow", int'(bus_a.overflow), e.ovf);
            end
        end
        prev_done = bus_a.done;
    end

    initial begin
        int gap_vals[8];
        int b2b_vals[8];
        gap_vals = '{6, 0, 12, 35, 1, 2, 3, 4};
        b2b_vals = '{7, 42, 0, 63, 63, 63, 63, 10};

        cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 6'd63, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

        // Eight products of 49: 392 wraps to 136 with overflow
        cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 6'd49, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        check("ovf_final_acc", int'(bus_a.acc), 136);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        check("idle_keeps_ovf", int'(bus_a.overflow), 1);

        // IDLE ignores p_valid and ack
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 6'd63, 1'b1);

        // Gapped batch with start pulses in ACCUM
        cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("start_clears_ovf", int'(bus_a.overflow), 0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 6'(gap_vals[i]), 1'b0);
            cycle(1'b0, 1'b1, 1'b0, 6'd63, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        end
        check("gap_acc", int'(bus_a.acc), 63);

        // DONE ignores products and start without ack
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 6'd63, 1'b0);

        // Back-to-back batch: ack and start together
        cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
        check("b2b_busy", int'(bus_a.busy), 1);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 6'(b2b_vals[i]), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

        // Reset mid-batch
        cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        check("mid_acc", int'(bus_a.acc), 20);
        cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 6'd33, 1'b0);
        check("post_reset_acc", int'(bus_a.acc), 0);

        // N=1 instance goes straight to DONE on the first product
        cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        check("n1_busy", int'(bus_b.busy), 1);
        cycle(1'b0, 1'b0, 1'b1, 6'd37, 1'b0);
        check("n1_done",  int'(bus_b.done),  1);
        check("n1_acc",   int'(bus_b.acc),   37);
        check("n1_count", int'(bus_b.count), 1);
        check("n1_idle",  int'(bus_b.busy),  0);
        cycle(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        check("n1_hold_acc", int'(bus_b.acc), 37);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
        check("n1_ack_done", int'(bus_b.done), 0);
        cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 7),
                  6'($urandom_range(0, 63)),
                  ($urandom_range(0, 2) == 0));
        end

        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 3x3 combinational multiplier.
- Consumes its 6-bit product P one sample per valid cycle and sums a batch of N products into a wider accumulator (dot-product / MAC style).
- Reports the result with a done/ack handshake and a sticky overflow flag.

Parameters:
- N, 8, number of products per batch (N >= 1).
- ACC_W, 9, accumulator width in bits; default holds 8 x 49 = 392 without overflow.
- CNT_W, $clog2(N+1), localparam, width of the product counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new batch; honoured in IDLE, and in DONE together with ack.
- p_valid  input  1  p_in holds a valid product this cycle.
- p_in  input  6  unsigned product from multiplier P[5:0].
- ack  input  1  consumer has taken the result; honoured only in DONE.
- acc  output  ACC_W  running and final sum, unsigned, modulo 2^ACC_W.
- count  output  CNT_W  number of products accepted in the current batch.
- busy  output  1  high in ACCUM.
- done  output  1  high in DONE; acc is final and stable.
- overflow  output  1  sticky; a carry out of ACC_W occurred in this batch.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at clk edge, overrides all other inputs): state=IDLE, acc=0, count=0, busy=0, done=0, overflow=0.
- Reset mid-batch discards the partial sum; the next batch requires a new start.
- FSM states: IDLE, ACCUM, DONE. busy and done are registered and reflect the current state.
- IDLE:
  - p_valid and ack are ignored.
  - start=1: acc<=0, count<=0, overflow<=0, go to ACCUM next cycle.
  - The start cycle does not accept a product.
- ACCUM:
  - Each cycle with p_valid=1: acc<=(acc+p_in) mod 2^ACC_W; count<=count+1.
  - Overflow: if acc+p_in >= 2^ACC_W, overflow<=1. It stays set until the next batch starts or reset.
  - p_valid=0: hold acc and count. Gaps of any length are allowed.
  - When count==N-1 and p_valid=1: accept that product and go to DONE. acc is final in the same edge, done=1 from the next cycle.
  - start is ignored in ACCUM.
  - Latency: done asserts one cycle after the N-th accepted product.
- DONE:
  - acc, count (=N) and overflow are held.
  - p_valid and p_in are ignored.
  - ack=1, start=0: go to IDLE; acc, count and overflow keep their values.
  - ack=1, start=1: clear acc, count and overflow, and go directly to ACCUM (back-to-back batches, one-cycle bubble).
  - start without ack is ignored.
- Arithmetic: p_in is zero-extended to ACC_W before the add; addition is unsigned.
- N=1: the first valid product goes straight to DONE.

Test Plan:
- Basic batch (N=4, ACC_W=9): start, then p_in=49 with p_valid=1 for 4 consecutive cycles -> count 1,2,3,4; done=1 on the cycle after the 4th; acc=196, overflow=0; ack -> IDLE, busy=0, done=0.
- Valid gaps (N=4): products 6,0,12,35 with p_valid low for 2 cycles between each -> acc=53 and count=4 only after the 4th valid; acc unchanged during gaps; done timing is relative to the 4th valid.
- Overflow (N=8, ACC_W=8): eight products of 49 -> acc=136 (392-256), overflow=1 in DONE. A new start clears overflow to 0 and acc to 0.
- Ignored inputs: start pulsed during ACCUM, and p_valid=1 with p_in=63 held in IDLE and DONE -> no effect on acc or count; done is not reasserted early.
- Back-to-back (N=2): in DONE assert ack=1 and start=1 together -> next cycle busy=1, acc=0, count=0. Products 7 and 42 -> acc=49, done=1.
- Reset mid-batch (N=4): after 2 products (acc=20), reset=1 for one cycle -> all outputs 0, state IDLE. Further p_valid pulses are ignored until start.
